// File: rtl/multicycle_datapath_if.sv
// Front-end bundle of the multicycle datapath: request handshake, direct
// register load, debug read port and the status/result outputs.
interface multicycle_datapath_if #(
   parameter int WIDTH = 32,
   parameter int NREGS = 16
);
   localparam int AW = $clog2(NREGS);

   logic             req_valid;
   logic             req_ready;
   logic [2:0]       req_op;
   logic [AW-1:0]    req_dst;
   logic [AW-1:0]    req_srca;
   logic [AW-1:0]    req_srcb;
   logic             req_use_imm;
   logic [WIDTH-1:0] req_imm;
   logic             ld_en;
   logic [AW-1:0]    ld_addr;
   logic [WIDTH-1:0] ld_data;
   logic [AW-1:0]    rd_addr;
   logic [WIDTH-1:0] rd_data;
   logic             done;
   logic [WIDTH-1:0] result;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic             busy;

   // Control unit side.
   modport master (
      output req_valid, req_op, req_dst, req_srca, req_srcb, req_use_imm, req_imm,
      output ld_en, ld_addr, ld_data, rd_addr,
      input  req_ready, rd_data, done, result, hi, lo, busy
   );

   // Datapath side.
   modport slave (
      input  req_valid, req_op, req_dst, req_srca, req_srcb, req_use_imm, req_imm,
      input  ld_en, ld_addr, ld_data, rd_addr,
      output req_ready, rd_data, done, result, hi, lo, busy
   );
endinterface

// File: rtl/multicycle_datapath.sv
// Multicycle register/ALU datapath. One request at a time is sequenced
// IDLE -> LOADY -> EXEC -> WB: operand A is moved into Y, the ALU combines Y
// with the bus (register B or the immediate) into Z, and Z is written back to
// the destination register (or to HI/LO for a multiply).
module multicycle_datapath #(
   parameter int WIDTH      = 32,
   parameter int NREGS      = 16,
   parameter int MUL_CYCLES = 4
) (
   input logic                  clock,
   input logic                  clear,
   multicycle_datapath_if.slave bus
);
   localparam int AW = $clog2(NREGS);
   localparam int SW = $clog2(WIDTH);
   localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(MUL_CYCLES - 1);

   typedef enum logic [2:0] {
      OP_ADD = 3'd0,
      OP_SUB = 3'd1,
      OP_AND = 3'd2,
      OP_OR  = 3'd3,
      OP_SHL = 3'd4,
      OP_SHR = 3'd5,
      OP_MUL = 3'd6,
      OP_NOT = 3'd7
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOADY = 2'd1,
      S_EXEC  = 2'd2,
      S_WB    = 2'd3
   } state_e;

   state_e             state_q, state_d;
   op_e                op_q, op_d;
   logic [AW-1:0]      dst_q, dst_d;
   logic [AW-1:0]      srca_q, srca_d;
   logic [AW-1:0]      srcb_q, srcb_d;
   logic               use_imm_q, use_imm_d;
   logic [WIDTH-1:0]   imm_q, imm_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [WIDTH-1:0]   y_q, y_d;
   logic [2*WIDTH-1:0] z_q, z_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic [WIDTH-1:0]   regs_q [NREGS];

   logic               reg_we;
   logic [AW-1:0]      reg_waddr;
   logic [WIDTH-1:0]   reg_wdata;
   logic [WIDTH-1:0]   bus_val;
   logic [2*WIDTH-1:0] alu_out;

   // Shared bus: operand B comes from the immediate or the register file.
   assign bus_val = use_imm_q ? imm_q : regs_q[srcb_q];

   // ALU: everything except MUL leaves the upper half of Z at zero.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no
      // path through the case can leave it unassigned and infer a latch.
      alu_out = '0;
      case (op_q)
         OP_ADD: alu_out = {{WIDTH{1'b0}}, y_q + bus_val};
         OP_SUB: alu_out = {{WIDTH{1'b0}}, y_q - bus_val};
         OP_AND: alu_out = {{WIDTH{1'b0}}, y_q & bus_val};
         OP_OR:  alu_out = {{WIDTH{1'b0}}, y_q | bus_val};
         OP_SHL: alu_out = {{WIDTH{1'b0}}, y_q << bus_val[SW-1:0]};
         OP_SHR: alu_out = {{WIDTH{1'b0}}, y_q >> bus_val[SW-1:0]};
         OP_MUL: alu_out = {{WIDTH{1'b0}}, y_q} * {{WIDTH{1'b0}}, bus_val};
         OP_NOT: alu_out = {{WIDTH{1'b0}}, ~bus_val};
         default: alu_out = '0;
      endcase
   end

   // Sequencer next state plus all register-transfer decisions.
   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      dst_d     = dst_q;
      srca_d    = srca_q;
      srcb_d    = srcb_q;
      use_imm_d = use_imm_q;
      imm_d     = imm_q;
      cnt_d     = cnt_q;
      y_d       = y_q;
      z_d       = z_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      reg_we    = 1'b0;
      reg_waddr = '0;
      reg_wdata = '0;
      case (state_q)
         S_IDLE: begin
            // A direct load in the accept cycle lands before LOADY reads srca.
            if (bus.ld_en) begin
               reg_we    = 1'b1;
               reg_waddr = bus.ld_addr;
               reg_wdata = bus.ld_data;
            end
            if (bus.req_valid) begin
               op_d      = op_e'(bus.req_op);
               dst_d     = bus.req_dst;
               srca_d    = bus.req_srca;
               srcb_d    = bus.req_srcb;
               use_imm_d = bus.req_use_imm;
               imm_d     = bus.req_imm;
               cnt_d     = '0;
               state_d   = S_LOADY;
            end
         end
         S_LOADY: begin
            y_d     = regs_q[srca_q];
            state_d = S_EXEC;
         end
         S_EXEC: begin
            if (op_q == OP_MUL && cnt_q != CNT_LAST) begin
               cnt_d = cnt_q + CW'(1);
            end else begin
               z_d     = alu_out;
               state_d = S_WB;
            end
         end
         S_WB: begin
            if (op_q == OP_MUL) begin
               hi_d = z_q[2*WIDTH-1:WIDTH];
               lo_d = z_q[WIDTH-1:0];
            end else begin
               reg_we    = 1'b1;
               reg_waddr = dst_q;
               reg_wdata = z_q[WIDTH-1:0];
            end
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Sequencer state register.
   always_ff @(posedge clock or negedge clear) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples its pre-edge inputs regardless of statement order.
      if (!clear) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Latched request, counter and Y/Z/HI/LO working registers.
   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         op_q      <= OP_ADD;
         dst_q     <= '0;
         srca_q    <= '0;
         srcb_q    <= '0;
         use_imm_q <= 1'b0;
         imm_q     <= '0;
         cnt_q     <= '0;
         y_q       <= '0;
         z_q       <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
      end else begin
         op_q      <= op_d;
         dst_q     <= dst_d;
         srca_q    <= srca_d;
         srcb_q    <= srcb_d;
         use_imm_q <= use_imm_d;
         imm_q     <= imm_d;
         cnt_q     <= cnt_d;
         y_q       <= y_d;
         z_q       <= z_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
      end
   end

   // General register file with a single write port.
   always_ff @(posedge clock or negedge clear) begin
      // NOTE: the register file must read zero after clear, so it is built from
      // flops with a reset loop rather than an unreset RAM.
      if (!clear) begin
         for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      end else if (reg_we) begin
         regs_q[reg_waddr] <= reg_wdata;
      end
   end

   assign bus.req_ready = (state_q == S_IDLE);
   assign bus.busy      = (state_q != S_IDLE);
   assign bus.done      = (state_q == S_WB);
   assign bus.result    = z_q[WIDTH-1:0];
   assign bus.hi        = hi_q;
   assign bus.lo        = lo_q;
   assign bus.rd_data   = regs_q[bus.rd_addr];
endmodule

// File: tb/tb_multicycle_datapath.sv
// Scoreboard bench for multicycle_datapath: stimulus pushes the expected
// result and the cycle in which done must appear; a negedge monitor pops and
// compares on every done pulse. Register/HI/LO contents are checked directly.
module tb_multicycle_datapath;
   localparam int WIDTH      = 32;
   localparam int NREGS      = 16;
   localparam int MUL_CYCLES = 4;

   typedef struct {
      logic [31:0] result;
      int          due;
   } exp_t;

   logic clock = 1'b0;
   logic clear = 1'b0;
   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];

   multicycle_datapath_if #(.WIDTH(WIDTH), .NREGS(NREGS)) bus ();

   multicycle_datapath #(
      .WIDTH(WIDTH), .NREGS(NREGS), .MUL_CYCLES(MUL_CYCLES)
   ) dut (
      .clock(clock),
      .clear(clear),
      .bus  (bus)
   );

   always #5 clock = ~clock;

   // Edge counter: read #1 after a rising edge it holds that edge's number.
   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check_reg(input string name, input logic [3:0] addr, input logic [31:0] exp);
      bus.rd_addr = addr;
      #1;
      check(name, bus.rd_data, exp);
   endtask

   task automatic load(input logic [3:0] addr, input logic [31:0] data);
      bus.ld_en   = 1'b1;
      bus.ld_addr = addr;
      bus.ld_data = data;
      tick();
      bus.ld_en = 1'b0;
   endtask

   // Offer a request until accepted, then scramble req_* to show they are not
   // sampled after accept. Returns #1 after the accept edge k. done must be
   // seen after edge k+2 (ALU ops) or edge k+1+MUL_CYCLES (MUL).
   task automatic issue(input logic [2:0] op, input logic [3:0] dst, input logic [3:0] srca,
                        input logic [3:0] srcb, input logic use_imm, input logic [31:0] imm,
                        input logic [31:0] exp, input bit push);
      int n = 0;
      bus.req_op      = op;
      bus.req_dst     = dst;
      bus.req_srca    = srca;
      bus.req_srcb    = srcb;
      bus.req_use_imm = use_imm;
      bus.req_imm     = imm;
      bus.req_valid   = 1'b1;
      while (!bus.req_ready && n < 50) begin
         tick();
         n++;
      end
      if (!bus.req_ready) begin
         check("issue_timeout", 64'd0, 64'd1);
         bus.req_valid = 1'b0;
         return;
      end
      tick();
      bus.req_valid   = 1'b0;
      bus.ld_en       = 1'b0;
      bus.req_op      = ~op;
      bus.req_dst     = ~dst;
      bus.req_srca    = ~srca;
      bus.req_srcb    = ~srcb;
      bus.req_use_imm = ~use_imm;
      bus.req_imm     = 32'hDEAD_BEEF;
      if (push) sb.push_back('{exp, cyc + ((op == 3'd6) ? MUL_CYCLES + 1 : 2)});
   endtask

   task automatic wait_idle();
      int n = 0;
      while (!bus.req_ready && n < 50) begin
         tick();
         n++;
      end
      if (!bus.req_ready) check("idle_timeout", 64'd0, 64'd1);
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clock) begin
      if (clear && bus.done) begin
         if (sb.size() == 0) begin
            check("unexpected_done", 64'd1, 64'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("done_result", bus.result, e.result);
            check("done_latency", cyc, e.due);
         end
      end
   end

   initial begin
      bus.req_valid   = 1'b0;
      bus.req_op      = 3'd0;
      bus.req_dst     = '0;
      bus.req_srca    = '0;
      bus.req_srcb    = '0;
      bus.req_use_imm = 1'b0;
      bus.req_imm     = '0;
      bus.ld_en       = 1'b0;
      bus.ld_addr     = '0;
      bus.ld_data     = '0;
      bus.rd_addr     = '0;
      repeat (3) tick();

      check("reset_ready", bus.req_ready, 1);
      check("reset_busy", bus.busy, 0);
      check("reset_done", bus.done, 0);
      check("reset_hi", bus.hi, 0);
      check("reset_lo", bus.lo, 0);
      check_reg("reset_r0", 4'd0, 32'd0);
      check_reg("reset_r15", 4'd15, 32'd0);
      clear = 1'b1;
      tick();

      // 1: ADD 5 + 7.
      load(4'd1, 32'd5);
      load(4'd2, 32'd7);
      issue(3'd0, 4'd3, 4'd1, 4'd2, 1'b0, 32'd0, 32'd12, 1'b1);
      wait_idle();
      check_reg("add_r3", 4'd3, 32'd12);

      // 2: SUB wraps; SHL uses only the low 5 bits of the amount.
      load(4'd1, 32'd0);
      load(4'd2, 32'd1);
      issue(3'd1, 4'd3, 4'd1, 4'd2, 1'b0, 32'd0, 32'hFFFF_FFFF, 1'b1);
      wait_idle();
      check_reg("sub_r3", 4'd3, 32'hFFFF_FFFF);
      load(4'd5, 32'd1);
      issue(3'd4, 4'd6, 4'd5, 4'd0, 1'b1, 32'd33, 32'd2, 1'b1);
      wait_idle();
      check_reg("shl_r6", 4'd6, 32'd2);

      // 3: MUL into HI/LO, destination untouched.
      load(4'd7, 32'hFFFF_FFFF);
      load(4'd8, 32'd2);
      load(4'd9, 32'd77);
      issue(3'd6, 4'd9, 4'd7, 4'd8, 1'b0, 32'd0, 32'hFFFF_FFFE, 1'b1);
      wait_idle();
      check("mul_hi", bus.hi, 32'd1);
      check("mul_lo", bus.lo, 32'hFFFF_FFFE);
      check_reg("mul_r9_kept", 4'd9, 32'd77);

      // 4: back-to-back R4 = R4 + R4; a request held while busy is ignored.
      load(4'd4, 32'd3);
      issue(3'd0, 4'd4, 4'd4, 4'd4, 1'b0, 32'd0, 32'd6, 1'b1);
      bus.req_valid = 1'b1;
      bus.req_op    = 3'd7;
      bus.req_dst   = 4'd10;
      bus.req_use_imm = 1'b1;
      bus.req_imm   = 32'd0;
      for (int i = 0; i < 3; i++) begin
         check("busy_not_ready", bus.req_ready, 0);
         tick();
      end
      issue(3'd0, 4'd4, 4'd4, 4'd4, 1'b0, 32'd0, 32'd12, 1'b1);
      wait_idle();
      check_reg("b2b_r4", 4'd4, 32'd12);
      check_reg("held_req_r10", 4'd10, 32'd0);

      // 5: load and accept together; load while busy is dropped.
      bus.ld_en   = 1'b1;
      bus.ld_addr = 4'd1;
      bus.ld_data = 32'd9;
      issue(3'd0, 4'd11, 4'd1, 4'd0, 1'b1, 32'd1, 32'd10, 1'b1);
      bus.ld_en   = 1'b1;
      bus.ld_addr = 4'd12;
      bus.ld_data = 32'd55;
      tick();
      bus.ld_en = 1'b0;
      wait_idle();
      check_reg("ld_accept_r11", 4'd11, 32'd10);
      check_reg("ld_accept_r1", 4'd1, 32'd9);
      check_reg("ld_busy_r12", 4'd12, 32'd0);

      // Remaining ALU ops.
      issue(3'd2, 4'd13, 4'd1, 4'd0, 1'b1, 32'h0000_000C, 32'd8, 1'b1);
      issue(3'd3, 4'd14, 4'd1, 4'd0, 1'b1, 32'h0000_0F00, 32'h0000_0F09, 1'b1);
      issue(3'd7, 4'd15, 4'd1, 4'd0, 1'b1, 32'h0F0F_0F0F, 32'hF0F0_F0F0, 1'b1);
      issue(3'd5, 4'd2, 4'd7, 4'd0, 1'b1, 32'd4, 32'h0FFF_FFFF, 1'b1);
      wait_idle();
      check_reg("and_r13", 4'd13, 32'd8);
      check_reg("not_r15", 4'd15, 32'hF0F0_F0F0);
      check_reg("shr_r2", 4'd2, 32'h0FFF_FFFF);

      // 6: clear in the middle of a MUL.
      issue(3'd6, 4'd9, 4'd7, 4'd8, 1'b0, 32'd0, 32'd0, 1'b0);
      tick();
      clear = 1'b0;
      #1;
      check("clr_ready", bus.req_ready, 1);
      check("clr_done", bus.done, 0);
      check("clr_hi", bus.hi, 0);
      check("clr_lo", bus.lo, 0);
      check_reg("clr_r7", 4'd7, 32'd0);
      repeat (2) tick();
      clear = 1'b1;
      repeat (8) tick();
      check("clr_ready_after", bus.req_ready, 1);
      check_reg("clr_r4", 4'd4, 32'd0);

      check("scoreboard_empty", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
